jk_bank_sequencer: RTL

- Controller that sequences a bank of WIDTH gate-level JK flip-flops. It accepts commands over a valid/ready handshake and converts each target value into per-bit J/K excitations from a shadow copy of the bank state.
- It strobes the bank one step at a time and checks the bank outputs against the expected value after every step.
- It sits between command logic and the JK bank: it drives the bank's J, K and clock-enable inputs and reads back its Q outputs.

---
 rtl/jk_bank_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: sequences a bank of JK flip-flops one verified step at a time.
// Each command is turned into per-bit J/K excitations from a shadow copy of the
// bank. The bank is strobed once per step, and its Q outputs are checked against
// the step target before the controller moves on.
module jk_bank_sequencer #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [WIDTH-1:0]  cmd_data,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [WIDTH-1:0]  q_fb,
   output logic [WIDTH-1:0]  j,
   output logic [WIDTH-1:0]  k,
   output logic              bank_en,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [WIDTH-1:0]  shadow
);

   localparam logic [2:0] OpHold      = 3'b000;
   localparam logic [2:0] OpClear     = 3'b001;
   localparam logic [2:0] OpSet       = 3'b010;
   localparam logic [2:0] OpLoad      = 3'b011;
   localparam logic [2:0] OpToggle    = 3'b100;
   localparam logic [2:0] OpCountUp   = 3'b101;
   localparam logic [2:0] OpCountDown = 3'b110;
   localparam logic [2:0] OpReserved  = 3'b111;

   typedef enum logic [1:0] {
      StIdle,
      StDrive,
      StSettle,
      StCheck
   } state_e;

   state_e              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [WIDTH-1:0]    data_q, data_d;
   logic [STEP_W-1:0]   steps_q, steps_d;
   logic [WIDTH-1:0]    shadow_q, shadow_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                accept;
   logic [STEP_W-1:0]   cmd_count;
   logic [WIDTH-1:0]    target;
   logic                fb_match;

   // Ready only in IDLE and never while reset is being applied.
   assign cmd_ready = (state_q == StIdle) && !rst;
   assign accept    = cmd_valid && cmd_ready;

   // Number of bank steps an incoming command needs.
   always_comb begin
      cmd_count = '0;
      case (cmd_op)
         OpHold:                 cmd_count = '0;
         OpCountUp, OpCountDown: cmd_count = cmd_steps;
         OpReserved:             cmd_count = '0;
         default:                cmd_count = STEP_W'(1);
      endcase
   end

   // Step target derived from the shadow; the shadow is stable for the whole step,
   // so the same value serves both the DRIVE excitation and the CHECK compare.
   always_comb begin
      target = shadow_q;
      case (op_q)
         OpClear:     target = '0;
         OpSet:       target = '1;
         OpLoad:      target = data_q;
         OpToggle:    target = shadow_q ^ data_q;
         OpCountUp:   target = shadow_q + WIDTH'(1);
         OpCountDown: target = shadow_q - WIDTH'(1);
         default:     target = shadow_q;
      endcase
   end

   assign fb_match = (q_fb == target);

   // Next-state logic for the sequencing FSM and its datapath registers.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      data_d   = data_q;
      steps_d  = steps_q;
      shadow_d = shadow_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               op_d   = cmd_op;
               data_d = cmd_data;
               if (cmd_op == OpReserved) begin
                  err_d = 1'b1;
               end else if (cmd_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  steps_d = cmd_count;
                  state_d = StDrive;
               end
            end
         end
         StDrive: begin
            state_d = StSettle;
         end
         StSettle: begin
            state_d = StCheck;
         end
         StCheck: begin
            if (fb_match) begin
               shadow_d = target;
               if (steps_q == STEP_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  steps_d = steps_q - STEP_W'(1);
                  state_d = StDrive;
               end
            end else begin
               // Resynchronise to what the bank actually holds; abandon the rest.
               shadow_d = q_fb;
               err_d    = 1'b1;
               state_d  = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         op_q     <= OpHold;
         data_q   <= '0;
         steps_q  <= '0;
         shadow_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         data_q   <= data_d;
         steps_q  <= steps_d;
         shadow_q <= shadow_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Bank excitation: only DRIVE drives J/K and strobes; set-only or reset-only
   // per bit, so J and K are never both high.
   always_comb begin
      j       = '0;
      k       = '0;
      bank_en = 1'b0;
      if (state_q == StDrive) begin
         j       = ~shadow_q & target;
         k       = shadow_q & ~target;
         bank_en = 1'b1;
      end
   end

   assign busy   = (state_q != StIdle);
   assign done   = done_q;
   assign err    = err_q;
   assign shadow = shadow_q;

endmodule
